// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double-dabble, one bit
// per clock) with a start/busy/done handshake.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN;
// without it the blank port is tied to zero and no blanking logic exists.
module bin2bcd_seq #(
  parameter int BIT_SZ = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIT_SZ-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(BIT_SZ + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [BIT_SZ-1:0] r_shift;
  logic [BIT_SZ-1:0] w_shift_next;
  logic [SW-1:0]     r_scratch;
  logic [SW-1:0]     w_scratch_next;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;
  logic [SW-1:0]     r_bcd;
  logic [SW-1:0]     w_bcd_next;
  logic              r_done;
  logic              w_done_next;
  logic [SW-1:0]     w_adj;

  // Add-3 correction: any scratch digit >= 5 gets +3 before the shift, so
  // that doubling it carries cleanly into the next digit.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  // Next-state and datapath update; every register keeps its value by default.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_scratch_next = r_scratch;
    w_count_next   = r_count;
    w_bcd_next     = r_bcd;
    w_done_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_shift_next   = bin_in;
          w_scratch_next = '0;
          w_count_next   = CW'(BIT_SZ);
          w_state_next   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // {scratch, shift} shifts left as one long register; the binary MSB
        // enters the units digit.
        w_shift_next   = {r_shift[BIT_SZ-2:0], 1'b0};
        w_scratch_next = {w_adj[SW-2:0], r_shift[BIT_SZ-1]};
        w_count_next   = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        // Publish the whole result at once so bcd_out is never partial.
        w_bcd_next   = r_scratch;
        w_done_next  = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_scratch <= w_scratch_next;
      r_count   <= w_count_next;
      r_bcd     <= w_bcd_next;
      r_done    <= w_done_next;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  // Units digit is never blanked so a zero value still shows "0".
  assign w_blank_next[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi = gi + 1) begin : g_blank
      // Digit gi blanks only when it and every more significant digit are zero.
      assign w_blank_next[gi] = (r_scratch[SW-1:4*gi] == '0);
    end
  endgenerate

  // Blank flags update together with bcd_out on the finishing edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_blank <= '0;
    end else if (r_state == ST_FINISH) begin
      r_blank <= w_blank_next;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: table vectors, handshake corner
// sequences and random values against a decimal-arithmetic model.
module tb_bin2bcd_seq;

  localparam int BIT_SZ = 10;
  localparam int DIGITS = 4;
  localparam int LAT    = BIT_SZ + 1;
`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic              clock;
  logic              reset;
  logic              start;
  logic [BIT_SZ-1:0] bin_in;
  logic              busy;
  logic              done;
  logic [15:0]       bcd_out;
  logic [3:0]        blank;

  int n_checks;
  int n_errors;

  bin2bcd_seq #(.BIT_SZ(BIT_SZ), .DIGITS(DIGITS)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out),
    .blank  (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic [3:0]  blank_on;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, blank by magnitude comparison.
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_blank(input int v);
    logic [3:0] r;
    int p;
    r = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      r[i] = BLANK_ON && (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  // Waits for done after the accepting edge; returns edges counted (bounded).
  task automatic wait_done(output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) seen = 1;
    end
  endtask

  task automatic run_conv(input int v, input logic [15:0] exp_bcd,
                          input logic [3:0] exp_blank, input string tag);
    int n;
    @(negedge clock);
    bin_in = BIT_SZ'(v);
    start  = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    bin_in = BIT_SZ'($urandom);
    check($sformatf("%s busy_after_accept", tag), 32'(busy), 32'd1);
    wait_done(n);
    check($sformatf("%s latency", tag), 32'(n), 32'(LAT));
    check($sformatf("%s bcd", tag), 32'(bcd_out), 32'(exp_bcd));
    check($sformatf("%s blank", tag), 32'(blank), 32'(exp_blank));
    check($sformatf("%s busy_low_at_done", tag), 32'(busy), 32'd0);
    @(posedge clock); #1;
    check($sformatf("%s done_one_cycle", tag), 32'(done), 32'd0);
    $display("conv %s bin=%0d bcd=%h blank=%b lat=%0d", tag, v, bcd_out, blank, n);
  endtask

  initial begin
    int n;
    int pulses;
    int v;
    n_checks = 0;
    n_errors = 0;
    reset  = 1'b1;
    start  = 1'b1;
    bin_in = 10'd123;

    tbl[0] = '{bin: 0,    bcd: 16'h0000, blank_on: 4'b1110};
    tbl[1] = '{bin: 1023, bcd: 16'h1023, blank_on: 4'b0000};
    tbl[2] = '{bin: 999,  bcd: 16'h0999, blank_on: 4'b1000};
    tbl[3] = '{bin: 9,    bcd: 16'h0009, blank_on: 4'b1110};
    tbl[4] = '{bin: 10,   bcd: 16'h0010, blank_on: 4'b1100};
    tbl[5] = '{bin: 100,  bcd: 16'h0100, blank_on: 4'b1000};
    tbl[6] = '{bin: 1000, bcd: 16'h1000, blank_on: 4'b0000};
    tbl[7] = '{bin: 505,  bcd: 16'h0505, blank_on: 4'b1000};

    // Reset held two cycles with start high: nothing starts.
    repeat (2) @(posedge clock);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd", 32'(bcd_out), 32'h0);
    check("reset blank", 32'(blank), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clock); #1;
    check("post_reset idle", 32'(busy), 32'd0);
    $display("reset sequence done");

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].bin, tbl[i].bcd, BLANK_ON ? tbl[i].blank_on : 4'b0000,
               $sformatf("tbl%0d", i));
    end

    // Start while busy is ignored.
    @(negedge clock);
    bin_in = 10'd37;
    start  = 1'b1;
    @(posedge clock); #1;                // E0
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    bin_in = 10'd500;
    start  = 1'b1;
    @(posedge clock); #1;                // E0+3
    start = 1'b0;
    check("ignore busy_mid", 32'(busy), 32'd1);
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("ignore pulses", 32'(pulses), 32'd1);
    check("ignore bcd", 32'(bcd_out), 32'h0037);
    check("ignore blank", 32'(blank), BLANK_ON ? 32'b1100 : 32'b0000);
    $display("ignore-start bcd=%h pulses=%0d", bcd_out, pulses);

    // Reset mid-conversion aborts.
    @(negedge clock);
    bin_in = 10'd512;
    start  = 1'b1;
    @(posedge clock); #1;                // E0
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;                // E0+5
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort bcd", 32'(bcd_out), 32'h0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("abort no_done", 32'(pulses), 32'd0);
    $display("abort bcd=%h pulses=%0d", bcd_out, pulses);
    run_conv(512, 16'h0512, BLANK_ON ? 4'b1000 : 4'b0000, "after_abort");

    // Back-to-back: start held during the done cycle.
    @(negedge clock);
    bin_in = 10'd5;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(n);
    pulses = (done === 1'b1) ? 1 : 0;
    check("b2b first_latency", 32'(n), 32'(LAT));
    check("b2b first_bcd", 32'(bcd_out), 32'h0005);
    bin_in = 10'd10;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b accepted", 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    if (done) pulses++;
    check("b2b gap", 32'(n), 32'(BIT_SZ + 2));
    check("b2b second_bcd", 32'(bcd_out), 32'h0010);
    for (int k = 0; k < 15; k++) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("b2b pulses", 32'(pulses), 32'd2);
    $display("back-to-back bcd=%h gap=%0d pulses=%0d", bcd_out, n, pulses);

    // Random values against the arithmetic model.
    for (int r = 0; r < 30; r++) begin
      v = int'($urandom_range(0, 1023));
      run_conv(v, model_bcd(v), model_blank(v), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 10-bit synchronous counter. It consumes the counter's binary count and produces packed BCD digits for the 7-segment display decoder stage. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake so that one small datapath serves any BIT_SZ.

Parameters:
BIT_SZ, 10, width of binary input; matches the counter's count width.
DIGITS, 4, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIT_SZ - 1; the integrator guarantees this and no runtime check is made.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion; sampled only in IDLE.
bin_in  input  BIT_SZ  binary value to convert; sampled on the edge that accepts start.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse; bcd_out is valid from this cycle onward.
bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit i in bits [4i+3:4i].
blank  output  DIGITS  leading-zero flags; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high, overrides everything including start):
  - state=IDLE; busy=0; done=0; bcd_out=0; blank=0.
  - Internal shift register, BCD scratch and bit counter are cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE: if start=1 at edge E0:
  - latch bin_in into the shift register;
  - clear BCD scratch;
  - load bit counter = BIT_SZ;
  - go to SHIFT; busy=1 from after E0.
  - If start=0, hold state; bcd_out and blank hold their last values.
- SHIFT: one iteration per edge:
  - Each scratch digit >= 5 gets +3 (4-bit add, no carry out of the digit).
  - Then {scratch, shift register} shifts left one bit; the MSB of bin moves into scratch bit 0.
  - Decrement bit counter.
  - The edge performing the last iteration (counter 1 -> 0) moves to FINISH.
  - Exactly BIT_SZ iterations: edges E0+1 .. E0+BIT_SZ.
- FINISH, at edge E0+BIT_SZ+1:
  - bcd_out <= scratch; blank updated; done <= 1; busy <= 0; state <= IDLE.
- done is high for exactly one cycle; it is deasserted on the next edge unconditionally.
- Latency: result and done are visible BIT_SZ+1 edges after the accepting edge (11 for the default).
- busy falls on the same edge that done rises.
- start while busy=1 (SHIFT or FINISH) is ignored. It is not queued and bin_in is not re-sampled.
- start during the done cycle is accepted, since state is already IDLE. Back-to-back throughput is one conversion per BIT_SZ+2 cycles.
- bcd_out changes only on a FINISH edge or on reset. It is never a partial result.
- Reset mid-conversion aborts: no done pulse, bcd_out=0, returns to IDLE.
- bin_in changing after acceptance has no effect on the current conversion.

Optional Feature:
Macro BIN2BCD_BLANK_EN.
- Defined:
  - On the FINISH edge, blank[i]=1 iff digit i and every higher digit are zero, for i >= 1.
  - blank[0] is always 0, so a value of 0 still shows "0".
  - blank is registered, changes only with bcd_out, and resets to 0.
- Undefined:
  - blank is tied to all zeros.
  - No blanking logic is synthesized.
  - The port remains present so the display stage interface is unchanged.

Test Plan:
1. Assert reset 2 cycles with start=1 -> busy=0, done=0, bcd_out=16'h0000, blank=4'b0000; no conversion is started.
2. Defaults, bin_in=0, start pulse at edge E0 -> done=1 only in the cycle after E0+11, bcd_out=16'h0000; blank=4'b1110 (macro on) or 4'b0000 (macro off).
3. bin_in=1023 -> bcd_out=16'h1023, blank=4'b0000. Then bin_in=999 -> bcd_out=16'h0999, blank=4'b1000 (macro on).
4. Start with bin_in=37, then at E0+3 set bin_in=500 and pulse start -> the second start is ignored; one done pulse; bcd_out=16'h0037, blank=4'b1100 (macro on).
5. Start with bin_in=512; assert reset at E0+5 for 1 cycle -> no done pulse; bcd_out=16'h0000; busy=0. Then a fresh start with bin_in=512 -> bcd_out=16'h0512.
6. Back-to-back: bin_in=5 accepted; start held high with bin_in=10 during the done cycle -> second conversion accepted on the next edge. Result 16'h0010 appears 12 edges after the first done (12 = BIT_SZ+2). Exactly two done pulses are observed.
